// File: rtl/pipe_pkg.sv
// Shared definitions for the action/data pipe: default payload width,
// the command record and the pipe latency seen by the collector.
package pipe_pkg;

    localparam int DATA_W   = 2;
    localparam int PIPE_LAT = 4;

    typedef struct packed {
        logic              action;
        logic [DATA_W-1:0] data;
    } pipe_cmd_t;

endpackage

// File: rtl/pipe_issue_fifo.sv
// Small synchronous FIFO buffering commands ahead of the issue stage.
// Flags come from a registered occupancy count, so they never depend on push/pop.
module pipe_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + {{AW{1'b0}}, 1'b1};
        end else if (!push_i && pop_i) begin
            count_d = count_q - {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/pipe_issue.sv
// Issue stage: buffers producer commands and launches them into the
// backpressure-free pipe, one per cycle, gated by downstream result credits.
module pipe_issue #(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4,
    parameter int DATA_W  = pipe_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_action,
    input  logic [DATA_W-1:0] s_data,
    input  logic              hold,
    input  logic              credit_ret,
    output logic              in_vld,
    output logic              action,
    output logic [DATA_W-1:0] data,
    output logic [3:0]        credits,
    output logic [7:0]        issued_cnt,
    output logic              err_credit
);

    localparam logic [3:0] CREDITS_MAX = 4'(CREDITS);

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic              push;
    logic              launch;
    logic [3:0]        post_launch;
    logic              ret_ok;

    logic              in_vld_q;
    logic              action_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        credits_q;
    logic [3:0]        credits_d;
    logic [7:0]        issued_q;
    logic              err_q;
    logic              err_d;

    pipe_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (launch),
        .wdata_i ({s_action, s_data}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign s_ready = !fifo_full;
    assign push    = s_valid && s_ready;
    assign launch  = !fifo_empty && (credits_q != 4'd0) && !hold;

    // A return is judged against the count after this cycle's launch, so a
    // return that coincides with a launch from a full pool is not an error.
    always_comb begin
        post_launch = credits_q - {3'b000, launch};
        ret_ok      = credit_ret && (post_launch != CREDITS_MAX);
        credits_d   = post_launch + {3'b000, ret_ok};
        err_d       = err_q || (credit_ret && !ret_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vld_q  <= 1'b0;
            action_q  <= 1'b0;
            data_q    <= '0;
            credits_q <= CREDITS_MAX;
            issued_q  <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            in_vld_q  <= launch;
            if (launch) begin
                action_q <= fifo_head[DATA_W];
                data_q   <= fifo_head[DATA_W-1:0];
            end
            credits_q <= credits_d;
            issued_q  <= issued_q + {7'd0, launch};
            err_q     <= err_d;
        end
    end

    assign in_vld     = in_vld_q;
    assign action     = action_q;
    assign data       = data_q;
    assign credits    = credits_q;
    assign issued_cnt = issued_q;
    assign err_credit = err_q;

endmodule

// File: tb/tb_pipe_issue.sv
// Self-checking bench for pipe_issue: directed stimulus feeds a scoreboard
// queue of expected launches; a negedge monitor pops and compares them.
module tb_pipe_issue;
    import pipe_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic        s_action;
    logic [1:0]  s_data;
    logic        hold;
    logic        credit_ret;
    logic        in_vld;
    logic        action;
    logic [1:0]  data;
    logic [3:0]  credits;
    logic [7:0]  issued_cnt;
    logic        err_credit;

    int checks   = 0;
    int failures = 0;
    int nLaunch  = 0;
    int base;

    pipe_cmd_t expQ [$];

    logic [2:0] burstVec [6];

    pipe_issue #(
        .DEPTH   (4),
        .CREDITS (4),
        .DATA_W  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_action   (s_action),
        .s_data     (s_data),
        .hold       (hold),
        .credit_ret (credit_ret),
        .in_vld     (in_vld),
        .action     (action),
        .data       (data),
        .credits    (credits),
        .issued_cnt (issued_cnt),
        .err_credit (err_credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d @%0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs starting just after a posedge; an accepted
    // push is recorded in the scoreboard before the edge that performs it.
    task automatic applyStimulus(input logic v, input logic a, input logic [1:0] d,
                                 input logic h, input logic c);
        s_valid    = v;
        s_action   = a;
        s_data     = d;
        hold       = h;
        credit_ret = c;
        if (v && s_ready) begin
            expQ.push_back('{action: a, data: d});
        end
        @(posedge clk);
        #1;
        s_valid    = 1'b0;
        s_action   = 1'b0;
        s_data     = 2'b00;
        hold       = 1'b0;
        credit_ret = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic retCredit(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    // Monitor: every launch must match the oldest accepted command.
    always @(negedge clk) begin
        pipe_cmd_t exp;
        if (rst_n && in_vld) begin
            nLaunch++;
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_launch actual=%0d_%0d required=none @%0t",
                         action, data, $time);
            end else begin
                exp = expQ.pop_front();
                checkOutput("launch_action", 32'(action), 32'(exp.action));
                checkOutput("launch_data", 32'(data), 32'(exp.data));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        burstVec[0] = 3'b101; burstVec[1] = 3'b010; burstVec[2] = 3'b111;
        burstVec[3] = 3'b000; burstVec[4] = 3'b110; burstVec[5] = 3'b001;

        rst_n = 1'b1; s_valid = 1'b0; s_action = 1'b0; s_data = 2'b00;
        hold = 1'b0; credit_ret = 1'b0;
        #3 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rst_s_ready", 32'(s_ready), 1);
        checkOutput("rst_in_vld", 32'(in_vld), 0);
        checkOutput("rst_action", 32'(action), 0);
        checkOutput("rst_data", 32'(data), 0);
        checkOutput("rst_credits", 32'(credits), 4);
        checkOutput("rst_issued", 32'(issued_cnt), 0);
        checkOutput("rst_err", 32'(err_credit), 0);
        rst_n = 1'b1;
        idle(1);

        // Three pushes: launches appear back-to-back two edges after the first push.
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        checkOutput("t1_vld_c0", 32'(in_vld), 0);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        checkOutput("t1_vld_c1", 32'(in_vld), 1);
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        checkOutput("t1_vld_c2", 32'(in_vld), 1);
        idle(1);
        checkOutput("t1_vld_c3", 32'(in_vld), 1);
        idle(1);
        checkOutput("t1_vld_c4", 32'(in_vld), 0);
        idle(2);
        checkOutput("t1_credits", 32'(credits), 1);
        checkOutput("t1_issued", 32'(issued_cnt), 3);
        retCredit(3);
        checkOutput("t1_refill", 32'(credits), 4);

        // Six pushes without returns: only four launch, then fill to full.
        base = nLaunch;
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, burstVec[i][2], burstVec[i][1:0], 1'b0, 1'b0);
        idle(3);
        checkOutput("t2_credits", 32'(credits), 0);
        checkOutput("t2_launches", nLaunch - base, 4);
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        checkOutput("t2_full_ready", 32'(s_ready), 0);
        base = nLaunch;
        retCredit(1);
        checkOutput("t2_ret_vld", 32'(in_vld), 0);
        idle(1);
        checkOutput("t2_one_vld", 32'(in_vld), 1);
        idle(3);
        checkOutput("t2_one_launch", nLaunch - base, 1);
        checkOutput("t2_ready_back", 32'(s_ready), 1);

        // Return at zero credits with queued work: launch only on the next cycle.
        retCredit(1);
        checkOutput("t3_no_vld", 32'(in_vld), 0);
        checkOutput("t3_credits1", 32'(credits), 1);
        idle(1);
        checkOutput("t3_vld", 32'(in_vld), 1);
        checkOutput("t3_credits0", 32'(credits), 0);

        // Drain the remaining two entries while refilling the credit pool.
        retCredit(6);
        idle(2);
        checkOutput("t4_credits_full", 32'(credits), 4);
        checkOutput("t4_issued", 32'(issued_cnt), 11);

        // Return coinciding with a launch from a full pool is legal.
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("t4_sim_vld", 32'(in_vld), 1);
        checkOutput("t4_sim_credits", 32'(credits), 4);
        checkOutput("t4_sim_err", 32'(err_credit), 0);
        idle(1);
        retCredit(1);
        checkOutput("t4_ovf_credits", 32'(credits), 4);
        checkOutput("t4_ovf_err", 32'(err_credit), 1);
        idle(3);
        checkOutput("t4_err_sticky", 32'(err_credit), 1);

        // Hold for five cycles with four entries queued, then release.
        base = nLaunch;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, burstVec[i+2][2], burstVec[i+2][1:0], 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        checkOutput("t5_hold_ready", 32'(s_ready), 0);
        checkOutput("t5_hold_vld", 32'(in_vld), 0);
        checkOutput("t5_hold_none", nLaunch - base, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            checkOutput("t5_release_vld", 32'(in_vld), 1);
        end
        idle(1);
        checkOutput("t5_after_vld", 32'(in_vld), 0);
        checkOutput("t5_issued", 32'(issued_cnt), 16);
        checkOutput("t5_credits", 32'(credits), 0);

        // Asynchronous reset in the middle of a burst.
        retCredit(4);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, burstVec[i][2], burstVec[i][1:0], 1'b1, 1'b0);
        idle(2);
        checkOutput("t6_pre_vld", 32'(in_vld), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_vld", 32'(in_vld), 0);
        expQ.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        base = nLaunch;
        idle(3);
        checkOutput("t6_empty_none", nLaunch - base, 0);
        checkOutput("t6_ready", 32'(s_ready), 1);
        checkOutput("t6_credits", 32'(credits), 4);
        checkOutput("t6_issued", 32'(issued_cnt), 0);
        checkOutput("t6_err", 32'(err_credit), 0);

        // 260 single launches with the credit recycled each time.
        base = nLaunch;
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, 1'(i), 2'(i >> 1), 1'b0, 1'b0);
            idle(1);
            retCredit(1);
        end
        idle(2);
        checkOutput("t6_wrap_launches", nLaunch - base, 260);
        checkOutput("t6_wrap_issued", 32'(issued_cnt), 4);
        checkOutput("t6_wrap_credits", 32'(credits), 4);
        checkOutput("t6_wrap_err", 32'(err_credit), 0);
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
